// File: rtl/prog_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_seq_ctrl
// Purpose  : Multi-cycle instruction sequencer. Owns the program counter and
//            a 4-entry branch-target LUT, inserts wait cycles for data-memory
//            instructions and flags each instruction commit with InstrValid.
// Ports    : Clk/Reset     - clock (rising edge), async active-low reset
//            Start         - launch program at PC=0 (IDLE/DONE only)
//            Branch/BrCond - branch request and ALU condition
//            HowHigh       - LUT index of the branch target
//            MemAccess     - current instruction is a load or store
//            Halt          - current instruction is halt
//            LutWe/LutAddr/LutData - LUT write port (IDLE/DONE only)
//            PC            - instruction address
//            InstrValid    - current instruction commits this cycle
//            Busy / Done   - sequencer status
// Revision : 1.0 - initial release
// ============================================================================
module prog_seq_ctrl #(
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Branch,
  input  logic [1:0]      HowHigh,
  input  logic            BrCond,
  input  logic            MemAccess,
  input  logic            Halt,
  input  logic            LutWe,
  input  logic [1:0]      LutAddr,
  input  logic [PC_W-1:0] LutData,
  output logic [PC_W-1:0] PC,
  output logic            InstrValid,
  output logic            Busy,
  output logic            Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0]      LAT     = 3'(MEM_LAT);
  localparam logic [PC_W-1:0] PC_LAST = '1;

  logic [1:0]      state, state_nx;
  logic [2:0]      cnt, cnt_nx;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] lut [4];

  logic idle_like;
  logic run_halt;
  logic run_stall;
  logic commit;
  logic advance;
  logic lut_wr;

  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE);
    run_halt  = (state == S_RUN) && Halt;
    // With zero latency a memory instruction behaves like any other one.
    run_stall = (state == S_RUN) && !Halt && MemAccess && (LAT != 3'd0);
    commit    = ((state == S_RUN) && !run_stall) ||
                ((state == S_WAIT) && (cnt == 3'd1));
    // Halt commits but never moves the PC, so branch is ignored with it.
    advance   = commit && !run_halt;
    lut_wr    = idle_like && LutWe;
  end

  assign InstrValid = commit;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = PC;
    case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_nx = S_RUN;
          pc_nx    = '0;
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_nx = S_DONE;
        end else if (run_stall) begin
          state_nx = S_WAIT;
          cnt_nx   = LAT;
        end
      end
      S_WAIT: begin
        if (cnt > 3'd1) begin
          cnt_nx = cnt - 3'd1;
        end else begin
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Next-PC selection on a committing non-halt instruction; a memory
    // instruction reaches this only in its final (commit) cycle, so its
    // branch is resolved there.
    if (advance) begin
      if (Branch && BrCond) begin
        pc_nx = lut[HowHigh];
      end else if (PC == PC_LAST) begin
        pc_nx    = '0;
        state_nx = S_DONE;
      end else begin
        pc_nx = PC + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      PC    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lut[i] <= '0;
      end
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      PC    <= pc_nx;
      Busy  <= (state_nx == S_RUN) || (state_nx == S_WAIT);
      Done  <= (state_nx == S_DONE);
      if (lut_wr) begin
        lut[LutAddr] <= LutData;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/prog_seq_ctrl.md
Name: prog_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the single-cycle datapath. Owns the program counter and a 4-entry branch-target LUT. It consumes the decoded control lines from the control decoder: branch, LUT index, memory access and halt. It inserts wait cycles for data-memory accesses and qualifies each instruction commit with InstrValid. Sits between instruction ROM addressing and the decoder; Start/Done give the testbench handshake.

Parameters:
PC_W, 10, program counter and LUT entry width.
MEM_LAT, 1, extra wait cycles per memory instruction (0..7); memory instruction occupies MEM_LAT+1 cycles.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  begin program at PC=0; sampled in IDLE and DONE only.
Branch  input  1  decoder branch line.
HowHigh  input  2  LUT index for branch target.
BrCond  input  1  ALU condition flag; branch taken when Branch&BrCond.
MemAccess  input  1  current instruction is a load or store (MemWrite|MemtoReg).
Halt  input  1  current instruction is halt.
LutWe  input  1  LUT write enable; accepted in IDLE and DONE only.
LutAddr  input  2  LUT write index.
LutData  input  PC_W  LUT write data.
PC  output  PC_W  instruction address.
InstrValid  output  1  current instruction commits this cycle; gates RegWrite/MemWrite.
Busy  output  1  high in RUN and WAIT.
Done  output  1  high in DONE.

Behaviour:
- Reset low, asynchronously: state=IDLE, PC=0, cnt=0, all LUT entries=0, InstrValid=0, Busy=0, Done=0. This applies mid-program too; no commit occurs in that cycle.
- States: IDLE, RUN, WAIT, DONE. InstrValid is combinational from state, cnt and inputs; all else is registered.
- IDLE: Start -> RUN, PC<=0. LutWe writes LUT[LutAddr]<=LutData. A write in the same cycle as Start is visible to the first instruction.
- RUN, input priority is Halt > MemAccess > normal:
  - Halt: InstrValid=1, PC held, -> DONE.
  - MemAccess with MEM_LAT>0: InstrValid=0, cnt<=MEM_LAT, -> WAIT, PC held.
  - Otherwise, or MemAccess with MEM_LAT=0: InstrValid=1, commit.
- WAIT: PC held; decoder inputs stay stable because PC is unchanged.
  - cnt>1: cnt<=cnt-1, InstrValid=0.
  - cnt==1: InstrValid=1, commit, -> RUN.
- Commit next PC:
  - Branch&BrCond: PC<=LUT[HowHigh], full PC_W replace, stay RUN.
  - Else if PC==2^PC_W-1: PC<=0, -> DONE (program overrun).
  - Else PC<=PC+1.
- DONE: Done=1, PC held. Start -> RUN, PC<=0, Done falls next cycle. LutWe accepted.
- Ignored: Start in RUN/WAIT; LutWe in RUN/WAIT (LUT unchanged).
- Branch together with Halt: halt wins, no redirect.
- Branch on a memory instruction is evaluated at its commit cycle.
- Branch target equal to the current PC is legal: a self-loop until BrCond falls.

Test Plan:
1. Reset low while RUN at PC=5 -> PC=0, Busy=0, Done=0 before the next edge; LUT reads 0. After release plus Start, PC=0.
2. Start, then ALU instructions at PC 0,1,2, Halt at PC=3 -> PC sequence 0,1,2,3 with InstrValid=1 each cycle. Done=1 the cycle after the Halt commit; PC holds 3.
3. In IDLE write LUT[2]=40, then Start. At PC=1 drive Branch=1, HowHigh=2, BrCond=1 -> PC=40. Repeat with BrCond=0 -> PC=2.
4. MEM_LAT=2, MemAccess at PC=4 -> InstrValid 0,0,1 over three cycles, Busy=1 throughout, PC=5 after the third cycle. With MEM_LAT=0 -> single-cycle commit.
5. PC_W=4, no Halt -> PC runs 0..15, the commit at 15 gives PC=0 and Done=1. Then Start -> RUN from PC=0, Done=0 next cycle.
6. During RUN pulse LutWe (LUT[0]=7) and Start -> LUT[0] stays 0, PC sequence undisturbed. Halt+Branch+BrCond together -> DONE, PC unchanged.
